// File: rtl/mips_core_pkg.sv
// Shared types and constants for the core; this slice holds the CDB arbiter's unit indices and payload types.
package mips_core_pkg;

  localparam int CDB_NUM_REQ = 4;

  localparam int CDB_ALU = 0;
  localparam int CDB_MUL = 1;
  localparam int CDB_LD  = 2;
  localparam int CDB_BR  = 3;

  localparam int CDB_TAG_W  = 4;
  localparam int CDB_DATA_W = 32;
  localparam int CDB_ADDR_W = 16;

  typedef struct packed {
    logic mtc0_op;
    logic done;
    logic fail;
    logic pass;
  } cdb_flags_t;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    logic [CDB_ADDR_W-1:0] addr;
    cdb_flags_t            flags;
  } cdb_payload_t;

  // Pointer width that stays legal for a single requester.
  function automatic int cdb_ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// Combinational rotate-priority picker: one-hot grant to the first set request at or after start.
module cdb_rr_picker
  import mips_core_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int PTR_W   = cdb_ptr_w(CDB_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   start,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int pos;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = (int'(start) + k) % NUM_REQ;
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = PTR_W'(pos);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among completing units, registered broadcast.
// Build option CDB_AGE_PRIORITY_EN: grant the oldest tag relative to rob_head, round-robin on ties.
module cdb_arbiter
  import mips_core_pkg::*;
#(
  parameter int NUM_REQ    = CDB_NUM_REQ,
  parameter int DATA_WIDTH = CDB_DATA_W,
  parameter int TAG_WIDTH  = CDB_TAG_W,
  parameter int ADDR_WIDTH = CDB_ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [TAG_WIDTH-1:0]          rob_head,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*4-1:0]          req_flags,
  output logic                          cdb_valid,
  output logic [TAG_WIDTH-1:0]          cdb_tag,
  output logic [DATA_WIDTH-1:0]         cdb_data,
  output logic [ADDR_WIDTH-1:0]         cdb_addr,
  output logic [3:0]                    cdb_flags
);

  localparam int PTR_W = cdb_ptr_w(NUM_REQ);

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_next;
  logic [NUM_REQ-1:0] pick_mask;
  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               allow;

`ifdef CDB_AGE_PRIORITY_EN
  logic [TAG_WIDTH-1:0] age [NUM_REQ];
  logic [TAG_WIDTH-1:0] min_age;

  // Age is distance from the ROB head; equal-age requesters fall through to round-robin.
  always_comb begin
    min_age   = '1;
    pick_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      age[i] = req_tag[i*TAG_WIDTH +: TAG_WIDTH] - rob_head;
      if (req_valid[i] && (age[i] < min_age)) min_age = age[i];
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_mask[i] = req_valid[i] && (age[i] == min_age);
    end
  end
`else
  logic unused_rob_head;
  assign unused_rob_head = ^rob_head;
  assign pick_mask       = req_valid;
`endif

  cdb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req   (pick_mask),
    .start (rr_ptr),
    .gnt   (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign allow     = rst_n & ~flush;
  assign req_ready = allow ? gnt : '0;
  assign rr_next   = (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + PTR_W'(1);

  logic [TAG_WIDTH-1:0]  sel_tag;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [ADDR_WIDTH-1:0] sel_addr;
  cdb_flags_t            sel_flags;

  always_comb begin
    sel_tag   = '0;
    sel_data  = '0;
    sel_addr  = '0;
    sel_flags = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_tag   = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_flags = cdb_flags_t'(req_flags[i*4 +: 4]);
      end
    end
  end

  // Stage p1: registered bus broadcast.
  logic                  vld_p1;
  logic [TAG_WIDTH-1:0]  tag_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  cdb_flags_t            flags_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      tag_p1   <= '0;
      data_p1  <= '0;
      addr_p1  <= '0;
      flags_p1 <= '0;
      rr_ptr   <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
      rr_ptr <= '0;
    end else begin
      vld_p1 <= gnt_any;
      if (gnt_any) begin
        tag_p1   <= sel_tag;
        data_p1  <= sel_data;
        addr_p1  <= sel_addr;
        flags_p1 <= sel_flags;
        rr_ptr   <= rr_next;
      end
    end
  end

  assign cdb_valid = vld_p1;
  assign cdb_tag   = tag_p1;
  assign cdb_data  = data_p1;
  assign cdb_addr  = addr_p1;
  assign cdb_flags = flags_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter; honours CDB_AGE_PRIORITY_EN for the age-priority vector.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int AW = 16;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic [TW-1:0]   rob_head;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic [N*AW-1:0] req_addr;
  logic [N*4-1:0]  req_flags;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [AW-1:0]   cdb_addr;
  logic [3:0]      cdb_flags;

  logic [TW-1:0] tag_a   [N];
  logic [DW-1:0] data_a  [N];
  logic [AW-1:0] addr_a  [N];
  logic [3:0]    flags_a [N];

  int n_checks;
  int n_fail;

  always_comb begin
    req_tag   = '0;
    req_data  = '0;
    req_addr  = '0;
    req_flags = '0;
    for (int i = 0; i < N; i++) begin
      req_tag[i*TW +: TW]   = tag_a[i];
      req_data[i*DW +: DW]  = data_a[i];
      req_addr[i*AW +: AW]  = addr_a[i];
      req_flags[i*4 +: 4]   = flags_a[i];
    end
  end

  cdb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .rob_head  (rob_head),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_addr  (req_addr),
    .req_flags (req_flags),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_addr  (cdb_addr),
    .cdb_flags (cdb_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    rob_head  = '0;
    req_valid = 4'hF;
    for (int i = 0; i < N; i++) begin
      tag_a[i]   = '0;
      data_a[i]  = '0;
      addr_a[i]  = '0;
      flags_a[i] = '0;
    end

    // Reset state
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'h0);
    tick();
    @(negedge clk);
    check("rst_valid", 64'(cdb_valid), 64'h0);
    check("rst_tag",   64'(cdb_tag),   64'h0);
    check("rst_data",  64'(cdb_data),  64'h0);
    tick();

    // Single ALU request
    rst_n     = 1'b1;
    tag_a[0]  = 4'd5;
    data_a[0] = 32'hDEADBEEF;
    req_valid = 4'b0001;
    @(negedge clk);
    check("single_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    check("single_valid", 64'(cdb_valid), 64'h1);
    check("single_tag",   64'(cdb_tag),   64'h5);
    check("single_data",  64'(cdb_data),  64'hDEADBEEF);
    check("single_idle",  64'(req_ready), 64'h0);
    tick();
    @(negedge clk);
    check("single_drop", 64'(cdb_valid), 64'h0);
    tick();

    // Restart from reset, then all four units continuously valid
    rst_n = 1'b0;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      tag_a[i]   = TW'(8 + i);
      data_a[i]  = 32'h100 + 32'(i);
      addr_a[i]  = (i == 2) ? 16'h1234 : 16'h0;
      flags_a[i] = (i == 3) ? 4'b0101 : 4'b0100;
    end
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("rr_ready_%0d", k), 64'(req_ready), 64'(1 << (k % 4)));
      if (k > 0) begin
        check($sformatf("rr_valid_%0d", k), 64'(cdb_valid), 64'h1);
        check($sformatf("rr_tag_%0d", k),   64'(cdb_tag),   64'(8 + ((k - 1) % 4)));
      end
      tick();
    end

    // Reset mid-stream
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", 64'(req_ready), 64'h0);
    check("mid_rst_prev",  64'(cdb_valid), 64'h1);
    check("mid_rst_ptag",  64'(cdb_tag),   64'h8);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 64'(cdb_valid), 64'h0);
    check("post_rst_tag",   64'(cdb_tag),   64'h0);
    check("post_rst_data",  64'(cdb_data),  64'h0);
    check("post_rst_addr",  64'(cdb_addr),  64'h0);
    check("post_rst_flags", 64'(cdb_flags), 64'h0);
    check("post_rst_ready", 64'(req_ready), 64'h1);
    tick();

    // Move rr_ptr to 3 by granting LD alone, then LD and BR together
    req_valid = 4'b0100;
    @(negedge clk);
    check("ld_alone", 64'(req_ready), 64'h4);
    tick();
    req_valid = 4'b1100;
    @(negedge clk);
    check("ldbr_ready", 64'(req_ready), 64'h8);
    check("ld_bcast_tag",  64'(cdb_tag),  64'hA);
    check("ld_bcast_addr", 64'(cdb_addr), 64'h1234);
    tick();
    req_valid = 4'b0100;
    @(negedge clk);
    check("ld_after_br", 64'(req_ready), 64'h4);
    check("br_bcast_tag",   64'(cdb_tag),   64'hB);
    check("br_bcast_flags", 64'(cdb_flags), 64'h5);
    tick();
    // rr_ptr=3: scan 3,0 picks ALU and leaves rr_ptr at 1
    req_valid = 4'b0001;
    @(negedge clk);
    check("wrap_ready", 64'(req_ready), 64'h1);
    tick();

    // Flush while ALU and MUL valid; without the flush MUL would win next
    req_valid = 4'b0011;
    flush     = 1'b1;
    @(negedge clk);
    check("flush_ready", 64'(req_ready), 64'h0);
    check("flush_prev",  64'(cdb_valid), 64'h1);
    check("flush_ptag",  64'(cdb_tag),   64'h8);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("post_flush_valid", 64'(cdb_valid), 64'h0);
    check("post_flush_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    check("post_flush_bcast", 64'(cdb_valid), 64'h1);
    tick();

    // Reset and flush together
    rst_n     = 1'b0;
    flush     = 1'b1;
    req_valid = 4'hF;
    @(negedge clk);
    check("rstfl_ready", 64'(req_ready), 64'h0);
    tick();
    rst_n     = 1'b1;
    flush     = 1'b0;
    req_valid = 4'b0000;
    @(negedge clk);
    check("rstfl_valid", 64'(cdb_valid), 64'h0);
    check("rstfl_tag",   64'(cdb_tag),   64'h0);
    tick();

    // Age priority: rob_head=14, ALU tag 2 (age 4), MUL tag 15 (age 1)
    rob_head  = 4'd14;
    tag_a[0]  = 4'd2;
    tag_a[1]  = 4'd15;
    req_valid = 4'b0011;
    @(negedge clk);
`ifdef CDB_AGE_PRIORITY_EN
    check("age_ready", 64'(req_ready), 64'h2);
`else
    check("age_ready", 64'(req_ready), 64'h1);
`endif
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
`ifdef CDB_AGE_PRIORITY_EN
    check("age_tag", 64'(cdb_tag), 64'hF);
`else
    check("age_tag", 64'(cdb_tag), 64'h2);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Arbitrates the single common data bus (CDB) between the functional units that complete out of order: ALU, multiplier, load unit and branch unit. Each cycle it picks one completing result and drives it, registered, onto the CDB. The reorder buffer and reservation stations consume the bus to mark entries ready and capture values. Losing requesters are back-pressured with a valid/ready handshake.

Parameters:
NUM_REQ, 4, number of requesting functional units (index 0 = ALU, 1 = MUL, 2 = LD, 3 = BR)
DATA_WIDTH, 32, result value width
TAG_WIDTH, 4, ROB tag width (equals ROB_DEPTH_BITS)
ADDR_WIDTH, 16, load address width carried for ROB bookkeeping

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush  in  1  branch-mispredict flush; kills in-flight and pending results
rob_head  in  TAG_WIDTH  ROB read-pointer index (oldest entry); used only with the optional feature
req_valid  in  NUM_REQ  per-unit result valid
req_ready  out  NUM_REQ  per-unit grant/accept, combinational
req_tag  in  NUM_REQ*TAG_WIDTH  per-unit ROB tag, flattened, unit i at [i*TAG_WIDTH +: TAG_WIDTH]
req_data  in  NUM_REQ*DATA_WIDTH  per-unit result value
req_addr  in  NUM_REQ*ADDR_WIDTH  per-unit load address (0 for non-loads)
req_flags  in  NUM_REQ*4  per-unit {mtc0_op, done, fail, pass}
cdb_valid  out  1  CDB broadcast valid
cdb_tag  out  TAG_WIDTH  broadcast ROB tag
cdb_data  out  DATA_WIDTH  broadcast value
cdb_addr  out  ADDR_WIDTH  broadcast load address
cdb_flags  out  4  broadcast {mtc0_op, done, fail, pass}

Behaviour:
- Reset (rst_n=0 at posedge): cdb_valid=0; cdb_tag, cdb_data, cdb_addr, cdb_flags = 0; rr_ptr=0. While rst_n=0, req_ready=0.
- Handshake: a requester holds valid and its payload stable until it sees req_ready=1 in the same cycle. The transfer occurs at that posedge.
- Grant: at most one req_ready bit high per cycle. The grant goes to the first valid requester scanning rr_ptr, rr_ptr+1, … mod NUM_REQ. If no request is valid, req_ready=0.
- Latency: the granted payload appears on the cdb_* outputs the cycle after the grant, with cdb_valid=1 for exactly one cycle per grant. Back-to-back grants give continuous cdb_valid.
- rr_ptr update: after a grant to unit g, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr is unchanged. Wrap from NUM_REQ-1 goes to 0.
- Starvation bound: a continuously valid requester is granted within NUM_REQ cycles.
- Flush:
  - In the flush cycle: req_ready=0 for all units, and cdb_valid<=0 at the next edge.
  - The already-registered broadcast in the flush cycle is still driven. The ROB ignores it because it is also flushing.
  - rr_ptr <= 0.
  - Requesters drop their valids themselves on flush.
- Simultaneous rst_n=0 and flush: reset wins; the result is identical.
- No internal queueing; the bus itself is the only storage stage.

Optional Feature:
CDB_AGE_PRIORITY_EN
- Defined: the grant goes to the valid requester whose tag is oldest, i.e. smallest (req_tag - rob_head) mod 2^TAG_WIDTH. Ties on age (not legal in normal operation) are broken by round-robin order from rr_ptr. rr_ptr still updates as above.
- Undefined: pure round-robin; rob_head is unused.

Decomposition:
- mips_core_pkg additions:
  - CDB_NUM_REQ = 4
  - unit index constants CDB_ALU=0, CDB_MUL=1, CDB_LD=2, CDB_BR=3
  - cdb_flags_t packed struct {mtc0_op, done, fail, pass}
  - cdb_payload_t struct {tag, data, addr, flags}
- One sub-module, cdb_rr_picker: a combinational rotate-priority one-hot picker (inputs: request mask, start pointer; output: one-hot grant and its index). The age comparison stays in cdb_arbiter under the macro.

Test Plan:
- Single request: ALU valid with tag=5, data=0xDEADBEEF → req_ready[0]=1 in the same cycle; next cycle cdb_valid=1, tag=5, data=0xDEADBEEF; following cycle cdb_valid=0.
- All four valid continuously from reset → grants in order 0,1,2,3,0; cdb_valid high every cycle after the first; each unit granted once per 4 cycles.
- LD (2) and BR (3) both valid with rr_ptr=3 → BR granted; rr_ptr=0; LD granted next cycle.
- Flush asserted while ALU and MUL are valid → req_ready=0 that cycle; cdb_valid=0 next cycle; rr_ptr=0; after the flush, ALU is granted first.
- Reset mid-stream (rst_n=0 for 1 cycle during continuous grants) → all cdb_* outputs 0 and req_ready=0 during reset; rr_ptr restarts at 0.
- CDB_AGE_PRIORITY_EN: rob_head=14, ALU tag=2, MUL tag=15 → MUL granted (age 1 vs 4); with the macro undefined and rr_ptr=0 → ALU granted.
